// File: rtl/amdemod_acc.sv
// amdemod_acc: readout-side AM demodulator / integrator.
// Mixes NSLICE parallel ADC samples per clock against a per-slice LO
// (conjugate mix: I = adc*cos, Q = -adc*sin). It sums across slices with
// a registered adder tree, then integrates over the gatein window. One
// complex result is delivered per window, with a one-cycle valid strobe.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high
//   gatein   integration window, qualifies samples on the same cycle
//   adc      NSLICE packed signed ADC samples, slice i at [i*DW +: DW]
//   locos    NSLICE packed signed LO cosine, same packing
//   losin    NSLICE packed signed LO sine, same packing
//   iout     signed integrated I of the last completed window
//   qout     signed integrated Q of the last completed window
//   nsamp    number of clocks integrated in the last window
//   valid    one-cycle strobe: iout/qout/nsamp/overflow were just updated
//   overflow last window's accumulation saturated
module amdemod_acc #(
  parameter int NSLICE = 16,
  parameter int DW     = 16,
  parameter int AW     = 48,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gatein,
  input  logic [NSLICE*DW-1:0] adc,
  input  logic [NSLICE*DW-1:0] locos,
  input  logic [NSLICE*DW-1:0] losin,
  output logic [AW-1:0]        iout,
  output logic [AW-1:0]        qout,
  output logic [CW-1:0]        nsamp,
  output logic                 valid,
  output logic                 overflow
);

  localparam int LG = $clog2(NSLICE);
  localparam int L  = 2 + LG;
  // Every tree level is kept at the final width. Wider operands are
  // equivalent to sign-extending one bit per level.
  localparam int PW = 2*DW + 1 + LG;
  localparam logic signed [AW:0] SMAX = (AW+1)'({1'b0, {(AW-1){1'b1}}});
  localparam logic signed [AW:0] SMIN = -SMAX;

  logic [NSLICE*DW-1:0]  adc_r, cos_r, sin_r;
  logic [L-1:0]          gsr;
  logic signed [PW-1:0]  ti [LG+1][NSLICE];
  logic signed [PW-1:0]  tq [LG+1][NSLICE];

  logic                  gd, gp;
  logic signed [AW-1:0]  acc_i, acc_q;
  logic [CW-1:0]         cnt;
  logic                  ovf;

  logic signed [AW-1:0]  ext_i, ext_q;
  logic signed [AW:0]    add_i, add_q;
  logic signed [AW-1:0]  nxt_i, nxt_q;
  logic                  sat_i, sat_q;

  function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [PW-1:0] ea, eb;
    ea = PW'(a);
    eb = PW'(b);
    return ea * eb;
  endfunction

  assign gd = gsr[L-1];

  // Mix + adder tree pipeline; the gate rides alongside in gsr.
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_r <= '0;
      cos_r <= '0;
      sin_r <= '0;
      gsr   <= '0;
      for (int unsigned k = 0; k <= LG; k++) begin
        for (int unsigned j = 0; j < NSLICE; j++) begin
          ti[k][j] <= '0;
          tq[k][j] <= '0;
        end
      end
    end else begin
      adc_r <= adc;
      cos_r <= locos;
      sin_r <= losin;
      gsr   <= {gsr[L-2:0], gatein};
      for (int unsigned i = 0; i < NSLICE; i++) begin
        ti[0][i] <= mul(adc_r[i*DW +: DW], cos_r[i*DW +: DW]);
        tq[0][i] <= -mul(adc_r[i*DW +: DW], sin_r[i*DW +: DW]);
      end
      for (int unsigned k = 1; k <= LG; k++) begin
        for (int unsigned j = 0; j < (NSLICE >> k); j++) begin
          ti[k][j] <= ti[k-1][2*j] + ti[k-1][2*j+1];
          tq[k][j] <= tq[k-1][2*j] + tq[k-1][2*j+1];
        end
      end
    end
  end

  // Saturating add at one extra bit; clamp symmetrically to +/-(2^(AW-1)-1).
  always_comb begin
    ext_i = AW'(ti[LG][0]);
    ext_q = AW'(tq[LG][0]);
    add_i = (AW+1)'(acc_i) + (AW+1)'(ext_i);
    add_q = (AW+1)'(acc_q) + (AW+1)'(ext_q);
    sat_i = 1'b0;
    sat_q = 1'b0;
    nxt_i = AW'(add_i);
    nxt_q = AW'(add_q);
    if (add_i > SMAX) begin
      nxt_i = AW'(SMAX);
      sat_i = 1'b1;
    end else if (add_i < SMIN) begin
      nxt_i = AW'(SMIN);
      sat_i = 1'b1;
    end
    if (add_q > SMAX) begin
      nxt_q = AW'(SMAX);
      sat_q = 1'b1;
    end else if (add_q < SMIN) begin
      nxt_q = AW'(SMIN);
      sat_q = 1'b1;
    end
  end

  // Window integrator: start, accumulate, end-of-window result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      gp       <= 1'b0;
      acc_i    <= '0;
      acc_q    <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      iout     <= '0;
      qout     <= '0;
      nsamp    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      gp    <= gd;
      valid <= 1'b0;
      if (gd && !gp) begin
        acc_i <= ext_i;
        acc_q <= ext_q;
        cnt   <= CW'(1);
        ovf   <= 1'b0;
      end else if (gd && gp) begin
        acc_i <= nxt_i;
        acc_q <= nxt_q;
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (sat_i || sat_q) ovf <= 1'b1;
      end else if (!gd && gp) begin
        iout     <= acc_i;
        qout     <= acc_q;
        nsamp    <= cnt;
        overflow <= ovf;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_amdemod_acc.sv
// Testbench for amdemod_acc: drives an AW=48 and an AW=40 instance with the
// same stimulus. A window-level reference model queues the expected result
// of each window; a monitor pops and compares whenever valid is seen.
module tb_amdemod_acc;
  localparam int NS = 16;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int L  = 6;
  localparam longint MAX48 = (longint'(1) << 47) - 1;
  localparam longint MAX40 = (longint'(1) << 39) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              gatein;
  logic [NS*DW-1:0]  adc, locos, losin;
  logic [47:0]       i48, q48;
  logic [39:0]       i40, q40;
  logic [CW-1:0]     n48, n40;
  logic              v48, v40, o48, o40;

  amdemod_acc #(.NSLICE(NS), .DW(DW), .AW(48), .CW(CW)) dut (
    .clk(clk), .reset(reset), .gatein(gatein), .adc(adc), .locos(locos),
    .losin(losin), .iout(i48), .qout(q48), .nsamp(n48), .valid(v48),
    .overflow(o48));

  amdemod_acc #(.NSLICE(NS), .DW(DW), .AW(40), .CW(CW)) dut40 (
    .clk(clk), .reset(reset), .gatein(gatein), .adc(adc), .locos(locos),
    .losin(losin), .iout(i40), .qout(q40), .nsamp(n40), .valid(v40),
    .overflow(o40));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint i48, q48, i40, q40;
    int     n;
    bit     o48, o40;
    int     at;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nwin   = 0;
  longint li48, lq48, li40;
  int     ln;
  bit     lo48, lo40;

  // reference model state
  bit     in_win = 0;
  longint ai48, aq48, ai40, aq40;
  int     cnt;
  bit     ov48, ov40;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic sat_add(inout longint acc, input longint s, input longint mx,
                         inout bit ov);
    acc = acc + s;
    if (acc > mx) begin acc = mx; ov = 1'b1; end
    else if (acc < -mx) begin acc = -mx; ov = 1'b1; end
  endtask

  // One clock: apply inputs, update the model for the edge that samples them.
  task automatic drive(input bit g, input bit r);
    longint sI, sQ;
    logic signed [DW-1:0] a, c, s;
    int e;
    gatein = g;
    reset  = r;
    e = cyc + 1;
    sI = 0;
    sQ = 0;
    for (int i = 0; i < NS; i++) begin
      a = adc[i*DW +: DW];
      c = locos[i*DW +: DW];
      s = losin[i*DW +: DW];
      sI = sI + longint'(a) * longint'(c);
      sQ = sQ - longint'(a) * longint'(s);
    end
    if (r) begin
      in_win = 1'b0;
    end else if (g) begin
      if (!in_win) begin
        ai48 = sI; aq48 = sQ; ai40 = sI; aq40 = sQ;
        cnt = 1; ov48 = 1'b0; ov40 = 1'b0; in_win = 1'b1;
      end else begin
        sat_add(ai48, sI, MAX48, ov48);
        sat_add(aq48, sQ, MAX48, ov48);
        sat_add(ai40, sI, MAX40, ov40);
        sat_add(aq40, sQ, MAX40, ov40);
        if (cnt < 65535) cnt++;
      end
    end else if (in_win) begin
      sbq.push_back('{i48: ai48, q48: aq48, i40: ai40, q40: aq40, n: cnt,
                      o48: ov48, o40: ov40, at: e + L});
      in_win = 1'b0;
      nwin++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic set_dc(input logic [15:0] a, input logic [15:0] c,
                        input logic [15:0] s);
    for (int i = 0; i < NS; i++) begin
      adc[i*DW +: DW]   = a;
      locos[i*DW +: DW] = c;
      losin[i*DW +: DW] = s;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NS; i++) begin
      adc[i*DW +: DW]   = 16'($urandom);
      locos[i*DW +: DW] = 16'($urandom);
      losin[i*DW +: DW] = 16'($urandom);
    end
  endtask

  // Monitor: every valid must match the oldest queued window, on its cycle.
  always @(negedge clk) begin
    if (v48 || v40) begin
      nvalid++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid48=%0d valid40=%0d expected no valid (cycle %0d)",
                 v48, v40, cyc);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("valid_cycle", longint'(cyc), longint'(x.at));
        chk("valid48", longint'(v48), 1);
        chk("valid40", longint'(v40), 1);
        chk("iout48", longint'($signed(i48)), x.i48);
        chk("qout48", longint'($signed(q48)), x.q48);
        chk("nsamp48", longint'(n48), longint'(x.n));
        chk("ovf48", longint'(o48), longint'(x.o48));
        chk("iout40", longint'($signed(i40)), x.i40);
        chk("qout40", longint'($signed(q40)), x.q40);
        chk("nsamp40", longint'(n40), longint'(x.n));
        chk("ovf40", longint'(o40), longint'(x.o40));
        li48 = longint'($signed(i48));
        lq48 = longint'($signed(q48));
        li40 = longint'($signed(i40));
        ln   = int'(n48);
        lo48 = o48;
        lo40 = o40;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nv0;
    reset = 1'b1;
    gatein = 1'b0;
    set_dc(16'h0, 16'h0, 16'h0);
    repeat (3) drive(1'b0, 1'b1);
    chk("rst_iout48", longint'(i48), 0);
    chk("rst_qout48", longint'(q48), 0);
    chk("rst_nsamp48", longint'(n48), 0);
    chk("rst_valid48", longint'(v48), 0);
    chk("rst_ovf48", longint'(o48), 0);
    chk("rst_iout40", longint'(i40), 0);
    chk("rst_valid40", longint'(v40), 0);
    idle(2);

    // DC mix
    set_dc(16'h4000, 16'h7fff, 16'h0000);
    repeat (10) drive(1'b1, 1'b0);
    idle(L + 4);
    chk("t1_iout", li48, 64'sd85896724480);
    chk("t1_qout", lq48, 0);
    chk("t1_nsamp", longint'(ln), 10);

    // Quadrature
    set_dc(16'h4000, 16'h0000, 16'h7fff);
    repeat (4) drive(1'b1, 1'b0);
    idle(L + 4);
    chk("t2_iout", li48, 0);
    chk("t2_qout", lq48, -64'sd34358689792);
    chk("t2_nsamp", longint'(ln), 4);

    // Back-to-back windows with a single low cycle
    set_dc(16'h4000, 16'h7fff, 16'h0000);
    nv0 = nvalid;
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b0);
    idle(L + 4);
    chk("t3_valids", longint'(nvalid - nv0), 2);
    chk("t3_nsamp", longint'(ln), 5);
    chk("t3_iout", li48, 64'sd42948362240);

    // Saturation on the AW=40 instance, then a clean short window
    set_dc(16'h8000, 16'h8000, 16'h0000);
    repeat (40) drive(1'b1, 1'b0);
    idle(L + 4);
    chk("t4_iout40", li40, MAX40);
    chk("t4_ovf40", longint'(lo40), 1);
    chk("t4_ovf48", longint'(lo48), 0);
    repeat (2) drive(1'b1, 1'b0);
    idle(L + 4);
    chk("t4b_ovf40", longint'(lo40), 0);
    chk("t4b_iout40", li40, 64'sd34359738368);

    // Reset in the middle of a window: discarded, outputs cleared
    set_dc(16'h4000, 16'h7fff, 16'h0000);
    nv0 = nvalid;
    repeat (2) drive(1'b1, 1'b0);
    repeat (8) drive(1'b1, 1'b1);
    chk("t5_iout_zero", longint'(i48), 0);
    chk("t5_nsamp_zero", longint'(n48), 0);
    chk("t5_ovf40_zero", longint'(o40), 0);
    idle(L + 4);
    chk("t5_no_valid", longint'(nvalid - nv0), 0);
    repeat (2) drive(1'b1, 1'b0);
    idle(L + 4);
    chk("t5_nsamp", longint'(ln), 2);
    chk("t5_iout", li48, 64'sd17179344896);

    // Random windows, random data on every cycle including gaps
    for (int w = 0; w < 1000; w++) begin
      int len, gap;
      len = $urandom_range(1, 8);
      gap = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin rand_data(); drive(1'b1, 1'b0); end
      for (int k = 0; k < gap; k++) begin rand_data(); drive(1'b0, 1'b0); end
    end
    idle(L + 6);
    chk("valid_count", longint'(nvalid), longint'(nwin));
    chk("queue_empty", longint'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
